// File: rtl/fwd_pkg.sv
// fwd_pkg: forwarding source codes shared by the operand muxes and the top level
package fwd_pkg;
   localparam int SRC_W = 3;
   localparam logic [SRC_W-1:0] FWD_RF   = 3'd0;
   localparam logic [SRC_W-1:0] FWD_MEM  = 3'd1;
   localparam logic [SRC_W-1:0] FWD_LOAD = 3'd2;
   localparam logic [SRC_W-1:0] FWD_LAT  = 3'd3;
   localparam logic [SRC_W-1:0] FWD_WB   = 3'd4;
   localparam logic [SRC_W-1:0] FWD_HOLD = 3'd5;
endpackage

// File: rtl/fwd_operand_mux.sv
// fwd_operand_mux: one EX operand's match, priority mux, hazard term and stall-hold register
module fwd_operand_mux
   import fwd_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              stall,
   input  logic              used,
   input  logic [REG_AW-1:0] rs,
   input  logic [XLEN-1:0]   rs_data,
   input  logic              rs_busy,
   input  logic              mem_reg_write,
   input  logic              mem_mem_read,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_result,
   input  logic [XLEN-1:0]   mem_data,
   input  logic              mem_data_valid,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_rd_data,
   input  logic              lat_done,
   input  logic [REG_AW-1:0] lat_done_rd,
   input  logic [XLEN-1:0]   lat_done_data,
   output logic [XLEN-1:0]   fwd,
   output logic [SRC_W-1:0]  src,
   output logic              hazard
);
   logic            hold_valid;
   logic [XLEN-1:0] hold_data;
   logic            nz, m_alu, m_ld, m_lat, m_wb, fresh;
   always_comb begin
      nz     = rs != '0;
      m_alu  = nz && mem_reg_write && !mem_mem_read && mem_rd == rs;
      m_ld   = nz && mem_mem_read && mem_rd == rs;
      m_lat  = nz && lat_done && lat_done_rd == rs;
      m_wb   = nz && wb_reg_write && wb_rd == rs;
      src    = m_alu ? FWD_MEM : (m_ld && mem_data_valid) ? FWD_LOAD : m_lat ? FWD_LAT :
               m_wb ? FWD_WB : (nz && hold_valid) ? FWD_HOLD : FWD_RF;
      fwd    = src == FWD_MEM  ? mem_result :
               src == FWD_LOAD ? mem_data :
               src == FWD_LAT  ? lat_done_data :
               src == FWD_WB   ? wb_rd_data :
               src == FWD_HOLD ? hold_data : rs_data;
      fresh  = src != FWD_RF && src != FWD_HOLD;
      hazard = used && nz && ((m_ld && !mem_data_valid) || (rs_busy && !m_lat));
   end
   // values retiring during a stall are parked here until EX advances
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (stall && fresh) begin
         hold_valid <= 1'b1;
         hold_data  <= fwd;
      end else if (!stall || flush) begin
         hold_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: EX operand forwarding, long-latency scoreboard, stall generation and stall counter
module forwarding_scoreboard
   import fwd_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   ex_valid,
   input  logic [REG_AW-1:0]      ex_rs1,
   input  logic [REG_AW-1:0]      ex_rs2,
   input  logic                   ex_use_rs1,
   input  logic                   ex_use_rs2,
   input  logic [XLEN-1:0]        ex_rs1_data,
   input  logic [XLEN-1:0]        ex_rs2_data,
   input  logic                   ex_long,
   input  logic [REG_AW-1:0]      ex_rd,
   input  logic                   mem_reg_write,
   input  logic                   mem_mem_read,
   input  logic [REG_AW-1:0]      mem_rd,
   input  logic [XLEN-1:0]        mem_result,
   input  logic [XLEN-1:0]        mem_data,
   input  logic                   mem_data_valid,
   input  logic                   wb_reg_write,
   input  logic [REG_AW-1:0]      wb_rd,
   input  logic [XLEN-1:0]        wb_rd_data,
   input  logic                   lat_done,
   input  logic [REG_AW-1:0]      lat_done_rd,
   input  logic [XLEN-1:0]        lat_done_data,
   output logic [XLEN-1:0]        rs1_fwd,
   output logic [XLEN-1:0]        rs2_fwd,
   output logic [SRC_W-1:0]       fwd_src1,
   output logic [SRC_W-1:0]       fwd_src2,
   output logic                   stall,
   output logic [2**REG_AW-1:0]   sb_busy,
   output logic [CNT_W-1:0]       stall_cycles
);
   localparam int NUM_REGS = 2**REG_AW;
   localparam logic [NUM_REGS-1:0] BIT0 = NUM_REGS'(1);
   logic                hazard1, hazard2, waw, sb_set;
   logic [NUM_REGS-1:0] clr_mask, set_mask;
   fwd_operand_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_op1 (
      .clock(clock), .reset(reset), .flush(flush), .stall(stall), .used(ex_use_rs1),
      .rs(ex_rs1), .rs_data(ex_rs1_data), .rs_busy(sb_busy[ex_rs1]),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
      .mem_result(mem_result), .mem_data(mem_data), .mem_data_valid(mem_data_valid),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
      .lat_done(lat_done), .lat_done_rd(lat_done_rd), .lat_done_data(lat_done_data),
      .fwd(rs1_fwd), .src(fwd_src1), .hazard(hazard1)
   );
   fwd_operand_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_op2 (
      .clock(clock), .reset(reset), .flush(flush), .stall(stall), .used(ex_use_rs2),
      .rs(ex_rs2), .rs_data(ex_rs2_data), .rs_busy(sb_busy[ex_rs2]),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
      .mem_result(mem_result), .mem_data(mem_data), .mem_data_valid(mem_data_valid),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
      .lat_done(lat_done), .lat_done_rd(lat_done_rd), .lat_done_data(lat_done_data),
      .fwd(rs2_fwd), .src(fwd_src2), .hazard(hazard2)
   );
   always_comb begin
      waw      = ex_long && ex_rd != '0 && sb_busy[ex_rd] && !(lat_done && lat_done_rd == ex_rd);
      stall    = ex_valid && !flush && (hazard1 || hazard2 || waw);
      sb_set   = ex_valid && ex_long && !stall && !flush && ex_rd != '0;
      clr_mask = lat_done ? BIT0 << lat_done_rd : '0;
      set_mask = sb_set ? BIT0 << ex_rd : '0;
   end
   // set is applied after clear so a same-cycle reissue keeps the register busy
   always_ff @(posedge clock) begin
      if (reset) begin
         sb_busy      <= '0;
         stall_cycles <= '0;
      end else begin
         sb_busy <= ((sb_busy & ~clr_mask) | set_mask) & ~BIT0;
         if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end
endmodule
